seq_alu: RTL and testbench

Parametrised, multicycle successor to the 32-bit combinational ALU. Adds valid/ready handshakes on input and output, a registered result, a full N/Z/C/V flag set, variable-amount iterative shifts and an iterative multiply. Sits between the decode/operand-fetch stage and writeback. Upstream issues one operation at a time; downstream may apply backpressure.

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_iter.sv | 102 ++++++++++
 rtl/seq_alu.sv | 131 +++++++++++++
 tb/tb_seq_alu.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag bit positions.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle between operand fetch, the ALU and writeback.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] O;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, O, Z, N, C, V
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, O, Z, N, C, V
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative shift / shift-add multiply datapath; the first step is taken on the start edge.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    op_e                op_q;
    logic [WIDTH-1:0]   acc_q, lo_q, mcand_q;
    logic               carry_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               busy_q;

    op_e                cur_op;
    logic [SHAMT_W-1:0] shamt, cnt_d;
    logic [WIDTH-1:0]   s_acc, s_lo, s_mc, n_acc, n_lo;
    logic               s_carry, n_carry, do_step;
    logic [WIDTH:0]     hi_sum;

    // Step source is the live operands on start, the working registers otherwise
    always_comb begin
        shamt   = b[SHAMT_W-1:0];
        cur_op  = start ? op : op_q;
        s_acc   = acc_q;
        s_lo    = lo_q;
        s_mc    = mcand_q;
        s_carry = carry_q;
        do_step = 1'b1;
        cnt_d   = cnt_q - SHAMT_W'(1);
        done_c  = busy_q && (cnt_q == SHAMT_W'(1));
        if (start) begin
            s_acc   = (op == OP_MUL) ? '0 : a;
            s_lo    = b;
            s_mc    = a;
            s_carry = 1'b0;
            if (op == OP_MUL) begin
                cnt_d  = SHAMT_W'(WIDTH - 1);
                done_c = 1'b0;
            end else begin
                do_step = (shamt != '0);
                cnt_d   = (shamt == '0) ? '0 : shamt - SHAMT_W'(1);
                done_c  = (shamt <= SHAMT_W'(1));
            end
        end

        hi_sum  = {1'b0, s_acc} + (s_lo[0] ? {1'b0, s_mc} : '0);
        n_acc   = s_acc;
        n_lo    = s_lo;
        n_carry = s_carry;
        if (do_step) begin
            case (cur_op)
                OP_SLL: begin
                    n_carry = s_acc[WIDTH-1];
                    n_acc   = {s_acc[WIDTH-2:0], 1'b0};
                end
                OP_SRL: begin
                    n_carry = s_acc[0];
                    n_acc   = {1'b0, s_acc[WIDTH-1:1]};
                end
                default: {n_acc, n_lo} = {hi_sum, s_lo[WIDTH-1:1]};
            endcase
        end

        result_c = (cur_op == OP_MUL) ? n_lo : n_acc;
        carry_c  = (cur_op == OP_MUL) ? (|n_acc) : n_carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_ADD;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (start || busy_q) begin
                acc_q   <= n_acc;
                lo_q    <= n_lo;
                carry_q <= n_carry;
                cnt_q   <= cnt_d;
            end
            if (start) begin
                op_q    <= op;
                mcand_q <= a;
            end
            busy_q <= (start || busy_q) && !done_c;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU top: handshake FSM, single-cycle ops and flag generation.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int unsigned MSB = WIDTH - 1;

    state_e             state_q, state_d;
    op_e                op;
    logic               accept, iter_op, start_c, load;
    logic               iter_done_c, iter_carry_c;
    logic [WIDTH-1:0]   iter_result_c, alu_o, o_d;
    logic               alu_c, alu_v;
    logic [WIDTH:0]     sum, diff;
    logic [FLAG_W-1:0]  flags_d;

    assign op      = op_e'(bus.sel);
    assign accept  = bus.in_valid && bus.in_ready;
    assign iter_op = (op == OP_SLL) || (op == OP_SRL) || (op == OP_MUL);
    assign start_c = (state_q == S_IDLE) && accept && iter_op;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
        .op       (op),
        .a        (bus.A),
        .b        (bus.B),
        .done_c   (iter_done_c),
        .result_c (iter_result_c),
        .carry_c  (iter_carry_c)
    );

    // Single-cycle arithmetic and logic ops with their carry/overflow
    always_comb begin
        sum   = {1'b0, bus.A} + {1'b0, bus.B};
        diff  = {1'b0, bus.A} - {1'b0, bus.B};
        alu_o = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_o = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                alu_o = diff[MSB:0];
                alu_c = diff[WIDTH];
                alu_v = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
            end
            OP_AND:  alu_o = bus.A & bus.B;
            OP_OR:   alu_o = bus.A | bus.B;
            OP_XOR:  alu_o = bus.A ^ bus.B;
            default: alu_o = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        o_d     = alu_o;
        flags_d = '0;
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!iter_op) begin
                        load    = 1'b1;
                        state_d = S_DONE;
                    end else if (iter_done_c) begin
                        load    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (iter_done_c) begin
                    load    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (iter_op) begin
            o_d             = iter_result_c;
            flags_d[FLAG_C] = iter_carry_c;
            flags_d[FLAG_V] = 1'b0;
        end
        flags_d[FLAG_Z] = (o_d == '0);
        flags_d[FLAG_N] = o_d[MSB];
    end

    // Result and flags only move on entry to DONE; a reset discards any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.O         <= '0;
            bus.Z         <= 1'b0;
            bus.N         <= 1'b0;
            bus.C         <= 1'b0;
            bus.V         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.in_ready  <= (state_d == S_IDLE);
            bus.out_valid <= (state_d == S_DONE);
            if (load) begin
                bus.O <= o_d;
                bus.Z <= flags_d[FLAG_Z];
                bus.N <= flags_d[FLAG_N];
                bus.C <= flags_d[FLAG_C];
                bus.V <= flags_d[FLAG_V];
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: results, flags, latency, backpressure and mid-op reset.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Global watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op with out_ready=1; return result, flags {N,Z,C,V}, latency and
    // the number of sampled cycles with in_ready=0 up to the out_valid cycle.
    task automatic run_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ro, output logic [3:0] rf,
                          output int rl, output int nbusy);
        @(negedge clk);
        bus.sel      = s;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rl    = -1;
        nbusy = 0;
        for (int i = 1; i <= 100; i++) begin
            if (!bus.in_ready) nbusy++;
            if (bus.out_valid) begin
                rl = i;
                break;
            end
            @(negedge clk);
        end
        ro = bus.O;
        rf = {bus.N, bus.Z, bus.C, bus.V};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.O, bus.N, bus.Z, bus.C, bus.V} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b O=%h nzcv=%b%b%b%b, want rdy=1 vld=0 O=0 nzcv=0000",
                     bus.in_ready, bus.out_valid, bus.O, bus.N, bus.Z, bus.C, bus.V);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] o; logic [3:0] f; int l, nb;
        run_op(3'd0, 32'd20, 32'd5, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'd25, 4'b0000} || l !== 1) begin
            fails++;
            $display("FAIL add_20_5: got O=%h nzcv=%b lat=%0d, want O=00000019 nzcv=0000 lat=1", o, f, l);
        end
        run_op(3'd0, 32'h7FFF_FFFF, 32'd1, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h8000_0000, 4'b1001}) begin
            fails++;
            $display("FAIL add_ovf: got O=%h nzcv=%b, want O=80000000 nzcv=1001", o, f);
        end
        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h0, 4'b0110}) begin
            fails++;
            $display("FAIL add_carry: got O=%h nzcv=%b, want O=00000000 nzcv=0110", o, f);
        end
    endtask

    task automatic test_sub();
        logic [31:0] o; logic [3:0] f; int l, nb;
        run_op(3'd1, 32'd5, 32'd5, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h0, 4'b0100}) begin
            fails++;
            $display("FAIL sub_equal: got O=%h nzcv=%b, want O=00000000 nzcv=0100", o, f);
        end
        run_op(3'd1, 32'd5, 32'd20, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'hFFFF_FFF1, 4'b1010}) begin
            fails++;
            $display("FAIL sub_borrow: got O=%h nzcv=%b, want O=fffffff1 nzcv=1010", o, f);
        end
        run_op(3'd1, 32'h8000_0000, 32'd1, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h7FFF_FFFF, 4'b0001}) begin
            fails++;
            $display("FAIL sub_ovf: got O=%h nzcv=%b, want O=7fffffff nzcv=0001", o, f);
        end
    endtask

    task automatic test_logic();
        logic [31:0] o; logic [3:0] f; int l, nb;
        run_op(3'd3, 32'hF000_0000, 32'h0000_000F, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'hF000_000F, 4'b1000} || l !== 1) begin
            fails++;
            $display("FAIL or: got O=%h nzcv=%b lat=%0d, want O=f000000f nzcv=1000 lat=1", o, f, l);
        end
    endtask

    task automatic test_shift();
        logic [31:0] o; logic [3:0] f; int l, nb;
        run_op(3'd6, 32'd20, 32'd3, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'd2, 4'b0010} || l !== 3 || nb !== 3) begin
            fails++;
            $display("FAIL srl_20_3: got O=%h nzcv=%b lat=%0d notready=%0d, want O=00000002 nzcv=0010 lat=3 notready=3",
                     o, f, l, nb);
        end
        run_op(3'd6, 32'hFFFF_FFFF, 32'd5, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h07FF_FFFF, 4'b0010} || l !== 5) begin
            fails++;
            $display("FAIL srl_ones_5: got O=%h nzcv=%b lat=%0d, want O=07ffffff nzcv=0010 lat=5", o, f, l);
        end
        // Maximal shift; upper bits of B must be ignored
        run_op(3'd5, 32'd3, 32'hFFFF_FFFF, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h8000_0000, 4'b1010} || l !== 31) begin
            fails++;
            $display("FAIL sll_max: got O=%h nzcv=%b lat=%0d, want O=80000000 nzcv=1010 lat=31", o, f, l);
        end
        run_op(3'd5, 32'h0000_1234, 32'h0000_0100, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h0000_1234, 4'b0000} || l !== 1) begin
            fails++;
            $display("FAIL sll_zero: got O=%h nzcv=%b lat=%0d, want O=00001234 nzcv=0000 lat=1", o, f, l);
        end
        run_op(3'd6, 32'h8000_0000, 32'd1, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h4000_0000, 4'b0000} || l !== 1) begin
            fails++;
            $display("FAIL srl_one: got O=%h nzcv=%b lat=%0d, want O=40000000 nzcv=0000 lat=1", o, f, l);
        end
    endtask

    task automatic test_mul();
        logic [31:0] o; logic [3:0] f; int l, nb;
        run_op(3'd7, 32'd20, 32'd5, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'd100, 4'b0000} || l !== 32) begin
            fails++;
            $display("FAIL mul_20_5: got O=%h nzcv=%b lat=%0d, want O=00000064 nzcv=0000 lat=32", o, f, l);
        end
        run_op(3'd7, 32'h0001_0000, 32'h0001_0000, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h0, 4'b0110}) begin
            fails++;
            $display("FAIL mul_wrap: got O=%h nzcv=%b, want O=00000000 nzcv=0110", o, f);
        end
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'h1, 4'b0010}) begin
            fails++;
            $display("FAIL mul_max: got O=%h nzcv=%b, want O=00000001 nzcv=0010", o, f);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.sel      = 3'd4;
        bus.A        = 32'hF0F0_F0F0;
        bus.B        = 32'hFF00_FF00;
        bus.in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.in_ready, bus.O, bus.N, bus.Z, bus.C, bus.V} !== {1'b1, 1'b0, 32'h0FF0_0FF0, 4'b0000}) begin
            fails++;
            $display("FAIL xor_result: got vld=%b rdy=%b O=%h, want vld=1 rdy=0 O=0ff00ff0", bus.out_valid, bus.in_ready, bus.O);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.sel      = 3'(i);
            bus.A        = $urandom;
            bus.B        = $urandom;
            @(negedge clk);
            if (bus.O !== 32'h0FF0_0FF0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
                || {bus.N, bus.Z, bus.C, bus.V} !== 4'b0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL handoff_idle: got vld=%b rdy=%b, want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_extra_accept: got %0d cycles with out_valid=1, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] o; logic [3:0] f; int l, nb;
        int bad = 0;
        @(negedge clk);
        bus.sel      = 3'd7;
        bus.A        = 32'd20;
        bus.B        = 32'd5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.O, bus.N, bus.Z, bus.C, bus.V} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            fails++;
            $display("FAIL reset_mid_mul: got rdy=%b vld=%b O=%h nzcv=%b%b%b%b, want rdy=1 vld=0 O=0 nzcv=0000",
                     bus.in_ready, bus.out_valid, bus.O, bus.N, bus.Z, bus.C, bus.V);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL aborted_result: got %0d cycles not idle, want 0", bad);
        end
        run_op(3'd2, 32'hC, 32'hA, o, f, l, nb);
        tests++;
        if ({o, f} !== {32'd8, 4'b0000} || l !== 1) begin
            fails++;
            $display("FAIL and_after_reset: got O=%h nzcv=%b lat=%0d, want O=00000008 nzcv=0000 lat=1", o, f, l);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        rst           = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
